// File: rtl/adc_capture.sv
// ---------------------------------------------------------------------------
// adc_capture
//
// ADC front-end capture block. The ADC data clock and data bus are brought
// into the clk domain through synchroniser chains. One sample is captured per
// selected ADC clock edge, optionally converted from offset binary, and then
// decimated by a runtime-selectable power-of-two boxcar average. Results are
// buffered in a first-word-fall-through FIFO with a valid/ready output.
//
// Optional feature macro: ADC_CAPTURE_PEAK_EN
//   When defined, peak_max/peak_min track the extremes of the decimated
//   results and clr_peak reinitialises them.
//
// Ports:
//   clk          main clock
//   rst          asynchronous active-high reset
//   adc_clk_in   ADC data clock, asynchronous to clk (<= clk/4)
//   adc_data     ADC parallel data word
//   enable       capture enable; low discards any partial window
//   dec_log2     decimation exponent d (ratio 2^d), clamped to MAX_DEC_LOG2
//   m_data       FIFO head (signed sample), 0 while the FIFO is empty
//   m_valid      FIFO not empty
//   m_ready      consumer accepts m_data
//   fifo_level   FIFO occupancy
//   overflow     sticky flag: a result was dropped because the FIFO was full
//   clr_ovf      clears overflow and drop_cnt
//   drop_cnt     saturating count of dropped results
//   mon          top MON_W bits of the last result in unsigned form
//   peak_max     (ADC_CAPTURE_PEAK_EN) largest result since reset/clear
//   peak_min     (ADC_CAPTURE_PEAK_EN) smallest result since reset/clear
//   clr_peak     (ADC_CAPTURE_PEAK_EN) reinitialises the peak trackers
// ---------------------------------------------------------------------------
module adc_capture #(
  parameter int ADC_W        = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int EDGE_RISE    = 1,
  parameter int OFFSET_BIN   = 0,
  parameter int MAX_DEC_LOG2 = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int MON_W        = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 adc_clk_in,
  input  logic [ADC_W-1:0]                     adc_data,
  input  logic                                 enable,
  input  logic [$clog2(MAX_DEC_LOG2+1)-1:0]    dec_log2,
  output logic [ADC_W-1:0]                     m_data,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
  output logic                                 overflow,
  input  logic                                 clr_ovf,
  output logic [15:0]                          drop_cnt,
  output logic [MON_W-1:0]                     mon
`ifdef ADC_CAPTURE_PEAK_EN
  ,
  output logic signed [ADC_W-1:0]              peak_max,
  output logic signed [ADC_W-1:0]              peak_min,
  input  logic                                 clr_peak
`endif
);

  localparam int DEC_W = $clog2(MAX_DEC_LOG2 + 1);
  localparam int ACC_W = ADC_W + MAX_DEC_LOG2;
  localparam int CNT_W = MAX_DEC_LOG2 + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  // Flipping the MSB converts between offset binary and two's complement.
  localparam logic [ADC_W-1:0] MSB_BIT  = {1'b1, {(ADC_W-1){1'b0}}};
  localparam logic [ADC_W-1:0] CAP_FLIP = (OFFSET_BIN != 0) ? MSB_BIT : '0;

  // -------------------------------------------------------------------------
  // Synchronisers
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [ADC_W-1:0]       data_sync [SYNC_STAGES];
  logic                   clk_prev;
  logic                   adc_edge;

  // The data bus goes through the same depth as the clock so the word seen at
  // the detected edge is the one that was stable around the ADC clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= '0;
      clk_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
    end else begin
      clk_sync     <= {clk_sync[SYNC_STAGES-2:0], adc_clk_in};
      clk_prev     <= clk_sync[SYNC_STAGES-1];
      data_sync[0] <= adc_data;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
    end
  end

  assign adc_edge = (EDGE_RISE != 0) ? (!clk_prev &&  clk_sync[SYNC_STAGES-1])
                                     : ( clk_prev && !clk_sync[SYNC_STAGES-1]);

  // -------------------------------------------------------------------------
  // Decimator
  // -------------------------------------------------------------------------
  logic signed [ADC_W-1:0] sample;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        win_last;
  logic [DEC_W-1:0]        d_reg;
  logic [DEC_W-1:0]        d_clamped;
  logic [DEC_W-1:0]        d_win;
  logic signed [ADC_W-1:0] result_next;
  logic signed [ADC_W-1:0] res_data;
  logic                    res_valid;

  // The exponent in force for a window is sampled only at the window start,
  // so a mid-window dec_log2 change waits for the next window.
  always_comb begin
    sample    = signed'(data_sync[SYNC_STAGES-1] ^ CAP_FLIP);
    d_clamped = dec_log2;
    if (int'(dec_log2) > MAX_DEC_LOG2) d_clamped = DEC_W'(MAX_DEC_LOG2);
    d_win       = (cnt == '0) ? d_clamped : d_reg;
    win_last    = (CNT_W'(1) << d_win) - CNT_W'(1);
    acc_sum     = acc + ACC_W'(sample);
    result_next = ADC_W'(acc_sum >>> d_win);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      d_reg     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      res_valid <= 1'b0;
      if (!enable) begin
        acc <= '0;
        cnt <= '0;
      end else if (adc_edge) begin
        if (cnt == '0) d_reg <= d_clamped;
        if (cnt == win_last) begin
          acc       <= '0;
          cnt       <= '0;
          res_valid <= 1'b1;
          res_data  <= result_next;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output FIFO (first word fall through)
  // -------------------------------------------------------------------------
  logic [ADC_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic             drop;

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    m_valid    = (level != '0);
    full       = (level == LVL_W'(FIFO_DEPTH));
    pop        = m_valid && m_ready;
    wr_en      = res_valid && (!full || pop);
    drop       = res_valid && full && !pop;
    m_data     = m_valid ? mem[rd_ptr] : '0;
    fifo_level = level;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= res_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Overflow flag and drop counter
  // -------------------------------------------------------------------------
  // A drop in the clearing cycle wins so that it is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= drop;
      drop_cnt <= drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Monitor output: last result shifted into unsigned range
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mon <= '0;
    end else if (res_valid) begin
      mon <= MON_W'((res_data ^ MSB_BIT) >> (ADC_W - MON_W));
    end
  end

`ifdef ADC_CAPTURE_PEAK_EN
  // -------------------------------------------------------------------------
  // Peak trackers
  // -------------------------------------------------------------------------
  localparam logic signed [ADC_W-1:0] MOST_NEG = {1'b1, {(ADC_W-1){1'b0}}};
  localparam logic signed [ADC_W-1:0] MOST_POS = {1'b0, {(ADC_W-1){1'b1}}};

  // A result arriving together with clr_peak seeds both trackers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_max <= MOST_NEG;
      peak_min <= MOST_POS;
    end else if (clr_peak) begin
      peak_max <= res_valid ? res_data : MOST_NEG;
      peak_min <= res_valid ? res_data : MOST_POS;
    end else if (res_valid) begin
      if (res_data > peak_max) peak_max <= res_data;
      if (res_data < peak_min) peak_min <= res_data;
    end
  end
`endif

endmodule

// File: tb/tb_adc_capture.sv
// ---------------------------------------------------------------------------
// tb_adc_capture
//
// Self-checking bench for adc_capture in its default configuration. A
// behavioural model turns each driven ADC sample into expected decimated
// results with plain integer arithmetic; a monitor compares every word the
// consumer pops against that model. Directed sections cover latency, the
// decimation windows, overflow handling, enable gating and reset.
// ---------------------------------------------------------------------------
module tb_adc_capture;

  localparam int SYNC_STAGES = 2;
  localparam int FIFO_DEPTH  = 16;
  localparam int MAX_DEC     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        adc_clk_in;
  logic [15:0] adc_data;
  logic        enable;
  logic [2:0]  dec_log2;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        clr_ovf;
  logic [15:0] drop_cnt;
  logic [3:0]  mon;

  adc_capture dut (
    .clk        (clk),
    .rst        (rst),
    .adc_clk_in (adc_clk_in),
    .adc_data   (adc_data),
    .enable     (enable),
    .dec_log2   (dec_log2),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .drop_cnt   (drop_cnt),
    .mon        (mon)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Consumer behaviour: 0 never ready, 1 always ready, 2 random, 3 manual.
  int   ready_mode   = 0;
  logic ready_manual = 1'b0;

  // Reference model state.
  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];
  int          win_sum = 0;
  int          win_n   = 0;
  int          win_d   = 0;
  int          drops_model = 0;
  logic [15:0] last_res = 16'h0000;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int floorDiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic logic [3:0] monOf(input logic [15:0] r);
    return 4'((r ^ 16'h8000) >> 12);
  endfunction

  // Boxcar average of 2^d samples with floor rounding; d fixed at window start.
  task automatic modelCapture(input logic [15:0] s);
    int q;
    if (!enable) return;
    if (win_n == 0) win_d = (int'(dec_log2) > MAX_DEC) ? MAX_DEC : int'(dec_log2);
    win_sum = win_sum + int'($signed(s));
    win_n++;
    if (win_n == (1 << win_d)) begin
      q        = floorDiv(win_sum, 1 << win_d);
      last_res = 16'(q);
      if (exp_q.size() >= FIFO_DEPTH) drops_model++;
      else exp_q.push_back(last_res);
      win_n   = 0;
      win_sum = 0;
    end
  endtask

  task automatic setEnable(input logic v);
    enable = v;
    if (!v) begin
      win_n   = 0;
      win_sum = 0;
    end
  endtask

  // One ADC clock period: data set up while adc_clk_in is low, rising edge,
  // then enough clk cycles for capture and push to complete.
  task automatic applyStimulus(input logic [15:0] s);
    adc_data = s;
    repeat (3) @(posedge clk);
    #1;
    modelCapture(s);
    adc_clk_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("mon", 32'(mon), 32'(monOf(last_res)));
    adc_clk_in = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    checkOutput(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic expectGot(input string tag, input int n, input logic [15:0] v0, input logic [15:0] v1);
    checkOutput({tag, "_count"}, 32'(got_q.size()), 32'(n));
    if (n > 0 && got_q.size() > 0) checkOutput({tag, "_0"}, 32'(got_q.pop_front()), 32'(v0));
    if (n > 1 && got_q.size() > 0) checkOutput({tag, "_1"}, 32'(got_q.pop_front()), 32'(v1));
    got_q.delete();
  endtask

  // Consumer and scoreboard: anything popped must match the model's next word.
  always @(negedge clk) begin
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = ready_manual;
    endcase
    if (!rst && m_valid && m_ready) begin
      got_q.push_back(m_data);
      if (exp_q.size() == 0) checkOutput("unexpected_output", 32'(m_data), 32'hFFFF_FFFF);
      else checkOutput("m_data", 32'(m_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [15:0] dir_vals [3] = '{16'h8000, 16'h7FFF, 16'h0001};
  logic [3:0]  dir_mons [3] = '{4'd0, 4'd15, 4'd8};
  logic [15:0] ovf_vals [21];

  initial begin
    rst        = 1'b1;
    adc_clk_in = 1'b0;
    adc_data   = 16'h0000;
    enable     = 1'b0;
    dec_log2   = 3'd0;
    clr_ovf    = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rst_m_valid",  32'(m_valid),    32'd0);
    checkOutput("rst_level",    32'(fifo_level), 32'd0);
    checkOutput("rst_m_data",   32'(m_data),     32'd0);
    checkOutput("rst_overflow", 32'(overflow),   32'd0);
    checkOutput("rst_drop_cnt", 32'(drop_cnt),   32'd0);
    checkOutput("rst_mon",      32'(mon),        32'd0);
    rst = 1'b0;
    setEnable(1'b1);
    repeat (3) @(posedge clk);

    // d=0 directed: latency, data and mon for three extreme words.
    ready_mode = 3;
    for (int k = 0; k < 3; k++) begin
      adc_data = dir_vals[k];
      repeat (3) @(posedge clk);
      #1;
      modelCapture(dir_vals[k]);
      adc_clk_in = 1'b1;
      repeat (SYNC_STAGES + 1) @(posedge clk);
      #1;
      checkOutput("lat_early_valid", 32'(m_valid), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("lat_valid", 32'(m_valid), 32'd1);
      checkOutput("lat_data",  32'(m_data),  32'(dir_vals[k]));
      checkOutput("lat_mon",   32'(mon),     32'(dir_mons[k]));
      ready_manual = 1'b1;
      @(posedge clk);
      #1;
      ready_manual = 1'b0;
      adc_clk_in   = 1'b0;
      repeat (3) @(posedge clk);
    end
    got_q.delete();

    // d=2 windows, including a negative floor.
    ready_mode = 1;
    dec_log2   = 3'd2;
    applyStimulus(16'd3);
    applyStimulus(16'd4);
    applyStimulus(16'hFFFB);
    applyStimulus(16'hFFFA);
    expectGot("d2_neg", 1, 16'hFFFF, 16'h0);
    applyStimulus(16'd1);
    applyStimulus(16'd1);
    applyStimulus(16'd1);
    applyStimulus(16'd2);
    expectGot("d2_pos", 1, 16'h0001, 16'h0);

    // Out-of-range exponent clamps to the maximum window of 16 samples.
    dec_log2 = 3'd7;
    for (int k = 1; k <= 15; k++) applyStimulus(16'(k));
    checkOutput("clamp_early", 32'(got_q.size()), 32'd0);
    applyStimulus(16'd16);
    expectGot("clamp", 1, 16'd8, 16'h0);

    // Exponent change mid-window only applies to the following window.
    dec_log2 = 3'd2;
    applyStimulus(16'd10);
    applyStimulus(16'd20);
    dec_log2 = 3'd0;
    applyStimulus(16'd30);
    checkOutput("midwin_none", 32'(got_q.size()), 32'd0);
    applyStimulus(16'd40);
    applyStimulus(16'd7);
    expectGot("midwin", 2, 16'd25, 16'd7);

    // Enable low discards a partial window.
    dec_log2 = 3'd2;
    applyStimulus(16'd100);
    applyStimulus(16'd200);
    applyStimulus(16'd300);
    setEnable(1'b0);
    applyStimulus(16'd400);
    applyStimulus(16'd500);
    checkOutput("en_off_count", 32'(got_q.size()), 32'd0);
    checkOutput("en_off_level", 32'(fifo_level),   32'd0);
    setEnable(1'b1);
    for (int k = 0; k < 4; k++) applyStimulus(16'd8);
    expectGot("en_on", 1, 16'd8, 16'h0);

    // Overflow: 20 results into a 16-deep FIFO with no consumer.
    ready_mode  = 0;
    dec_log2    = 3'd0;
    drops_model = 0;
    for (int k = 0; k < 21; k++) ovf_vals[k] = 16'($urandom);
    for (int k = 0; k < 20; k++) applyStimulus(ovf_vals[k]);
    checkOutput("ovf_level",    32'(fifo_level), 32'd16);
    checkOutput("ovf_flag",     32'(overflow),   32'd1);
    checkOutput("ovf_drop_cnt", 32'(drop_cnt),   32'd4);
    checkOutput("ovf_drop_mdl", 32'(drop_cnt),   32'(drops_model));
    checkOutput("ovf_head",     32'(m_data),     32'(ovf_vals[0]));

    // Push and pop in the same cycle while full: both succeed.
    ready_mode   = 3;
    ready_manual = 1'b0;
    adc_data     = ovf_vals[20];
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(ovf_vals[20]);
    last_res   = ovf_vals[20];
    adc_clk_in = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;
    ready_manual = 1'b1;
    @(posedge clk);
    #1;
    ready_manual = 1'b0;
    checkOutput("full_pp_level", 32'(fifo_level), 32'd16);
    checkOutput("full_pp_drops", 32'(drop_cnt),   32'd4);
    checkOutput("full_pp_mon",   32'(mon),        32'(monOf(ovf_vals[20])));
    adc_clk_in = 1'b0;
    @(posedge clk);
    #1;
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    checkOutput("clr_ovf_flag", 32'(overflow), 32'd0);
    checkOutput("clr_ovf_cnt",  32'(drop_cnt), 32'd0);
    ready_mode = 1;
    waitDrain("ovf_drain");
    checkOutput("ovf_drain_level", 32'(fifo_level), 32'd0);
    got_q.delete();

    // Reset in the middle of traffic with 5 words queued.
    ready_mode = 0;
    for (int k = 0; k < 5; k++) applyStimulus(16'(k * 1000 + 1));
    checkOutput("pre_rst_level", 32'(fifo_level), 32'd5);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(m_valid),    32'd0);
    checkOutput("async_rst_level", 32'(fifo_level), 32'd0);
    checkOutput("async_rst_ovf",   32'(overflow),   32'd0);
    checkOutput("async_rst_mon",   32'(mon),        32'd0);
    exp_q.delete();
    got_q.delete();
    win_n    = 0;
    win_sum  = 0;
    last_res = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("post_rst_level", 32'(fifo_level), 32'd0);
    checkOutput("post_rst_valid", 32'(m_valid),    32'd0);

    // Randomised traffic against the model.
    ready_mode = 2;
    dec_log2   = 3'd0;
    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 7) == 0) dec_log2 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) setEnable(!enable);
      applyStimulus(16'($urandom));
    end
    ready_mode = 1;
    waitDrain("rand_drain");
    checkOutput("rand_overflow", 32'(overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_capture.md
Name: adc_capture

Overview:
Parametrised ADC front-end capture block; the successor to the ad-hoc double-latch sampler in the top level. Synchronises the ADC data clock and bus into the main clock domain and captures one sample per ADC clock edge. Applies optional offset-binary conversion and runtime-selectable power-of-two boxcar decimation, then buffers results in a FWFT FIFO with valid/ready output. Also provides an overflow flag, a drop counter and a coarse unsigned monitor output for pmod/LED debug.

Parameters:
ADC_W, 16, ADC sample width (bits)
SYNC_STAGES, 2, synchroniser depth for adc_clk_in and adc_data (>=2)
EDGE_RISE, 1, 1: capture on rising adc_clk_in edge; 0: falling
OFFSET_BIN, 0, 1: input is offset binary, invert MSB to get two's complement
MAX_DEC_LOG2, 4, maximum decimation exponent
FIFO_DEPTH, 16, output FIFO entries (power of two, >=2)
MON_W, 4, monitor output width (<= ADC_W)

Ports:
clk  in  1  main clock
rst  in  1  asynchronous, active-high reset
adc_clk_in  in  1  ADC data clock (asynchronous to clk, <= clk/4)
adc_data  in  ADC_W  ADC parallel data
enable  in  1  capture enable
dec_log2  in  $clog2(MAX_DEC_LOG2+1)  decimation exponent d; ratio 2^d
m_data  out  ADC_W  signed output sample (FIFO head)
m_valid  out  1  FIFO not empty
m_ready  in  1  consumer accepts m_data
fifo_level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
overflow  out  1  sticky: a result was dropped
clr_ovf  in  1  clears overflow and drop_cnt
drop_cnt  out  16  dropped results, saturating at 16'hFFFF
mon  out  MON_W  top MON_W bits of (last result + 2^(ADC_W-1)), unsigned

Behaviour:
- Reset (async assert, sync release by caller): all synchroniser flops 0, accumulator 0, sample counter 0, FIFO empty; m_valid=0, m_data=0, fifo_level=0, overflow=0, drop_cnt=0, mon=0.
- adc_clk_in and adc_data pass through SYNC_STAGES flops each. Edge = last two synced clock bits equal 01 (EDGE_RISE=1) or 10 (EDGE_RISE=0).
- On edge, the synced data word is captured; MSB inverted if OFFSET_BIN=1. Edge-to-capture: SYNC_STAGES+1 clk cycles after adc_clk_in transition.
- enable=0: no captures; accumulator and counter held at 0; FIFO continues to drain. Deasserting enable mid-window discards the partial window.
- Decimator: accumulator signed, ADC_W+MAX_DEC_LOG2 bits. d is latched when counter==0 (window start); values > MAX_DEC_LOG2 clamp to MAX_DEC_LOG2. Each captured sample is added. On the 2^d-th sample: result = (acc + sample) >>> d (arithmetic, floor), truncated to ADC_W; acc and counter cleared the same cycle. d=0: every sample is a result. Changing dec_log2 mid-window takes effect at the next window.
- Result push to FIFO the cycle after the final capture; mon updates the same cycle.
- FIFO: FWFT. m_data = head whenever m_valid=1. Pop when m_valid&&m_ready. Push into empty FIFO: m_valid rises the cycle after the push. Full+push+pop same cycle: both succeed, level unchanged. Full+push without pop: result dropped, overflow<=1, drop_cnt increments (saturating). m_ready while empty: no effect.
- clr_ovf: clears overflow and drop_cnt next cycle. Same-cycle clr_ovf and drop: overflow=1, drop_cnt=1.

Optional Feature:
ADC_CAPTURE_PEAK_EN: defined -> adds ports peak_max/peak_min (out, ADC_W, signed) and clr_peak (in, 1). These track the max/min of decimated results. Reset/clr_peak sets peak_max to most-negative and peak_min to most-positive. A result coincident with clr_peak is loaded as both peaks. Undefined -> ports and logic absent; all other behaviour identical.

Test Plan:
- Reset: rst=1 mid-stream with FIFO holding 5 entries -> m_valid=0, fifo_level=0, overflow=0 immediately (async); no push until a new edge after release.
- d=0, OFFSET_BIN=0: adc_data 16'h8000, 16'h7FFF, 16'h0001 on three rising edges -> m_data sequence -32768, 32767, 1; each appears SYNC_STAGES+2 cycles after its edge; mon = 0, 15, 8.
- d=2: samples 3, 4, -5, -6 -> one result floor(-4/4) = -1 (16'hFFFF); samples 1, 1, 1, 2 -> 1 (5>>>2).
- Decimation: dec_log2=7 with MAX_DEC_LOG2=4 -> result after 16 samples. Change d 2->0 mid-window -> current window completes after 4 samples.
- Overflow: m_ready=0, d=0, FIFO_DEPTH=16, 20 edges -> fifo_level=16, overflow=1, drop_cnt=4, head = first sample. Then m_ready=1 and a push on the same cycle while full -> level stays 16. clr_ovf -> drop_cnt=0.
- Enable toggle: d=2, enable low after 3 samples -> no output. Re-enable with 4 samples of 8 -> single result 8.
